// File: rtl/seq_detect_prog.sv
// seq_detect_prog: run-time programmable serial pattern detector.
//
// Watches a qualified serial bit stream for a programmable pattern of 1..MAX_LEN bits and
// raises a registered single-cycle pulse one clock after the completing bit is sampled.
// Overlapping and non-overlapping match modes are both supported.
//
// Optional feature macro: SEQ_MATCH_CNT_EN
//   defined   -> adds the saturating match_cnt output
//   undefined -> match_cnt port and counter are absent
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     in is sampled only when high
//   in           serial data bit
//   cfg_load     one-cycle strobe latching cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern  pattern, right-aligned; bit [len-1] is received first, bit [0] last
//   cfg_len      pattern length (valid range 1..MAX_LEN)
//   cfg_overlap  1 = overlapping, 0 = non-overlapping matches
//   out          registered match pulse
//   cfg_err      high while the active configuration has an invalid length
//   match_cnt    saturating match count (SEQ_MATCH_CNT_EN only)
module seq_detect_prog #(
    parameter int unsigned        MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0101),
    parameter int unsigned        DEF_LEN     = 3,
    parameter bit                 DEF_OVERLAP = 1'b1,
    parameter int unsigned        CNT_W       = 8,
    localparam int unsigned       LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               out,
    output logic               cfg_err
`ifdef SEQ_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    // Elaboration-time sanity check of the parameter set.
    if (MAX_LEN < 2 || DEF_LEN < 1 || DEF_LEN > MAX_LEN || CNT_W < 1) begin : g_param_check
        $error("seq_detect_prog: illegal parameter combination");
    end

    localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);

    // Active configuration
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic               cfg_err_q;

    // Detector state
    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               out_q;

    // Combinational helpers
    logic               cfg_len_ok;
    logic               accept;
    logic [MAX_LEN-1:0] shifted;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    always_comb begin
        cfg_len_ok = (cfg_len != '0) && (cfg_len <= MaxLenW);
        // Load has priority over data; an invalid configuration stalls the detector.
        accept     = in_valid && !cfg_load && !cfg_err_q;
        shifted    = {history_q[MAX_LEN-2:0], in};
        fill_inc   = (fill_q == MaxLenW) ? fill_q : fill_q + LEN_W'(1);

        // Only the low len bits take part in the compare.
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end

        match = accept
             && (((shifted ^ pattern_q) & len_mask) == '0)
             && (fill_inc >= len_q);

        history_d = history_q;
        fill_d    = fill_q;
        if (accept) begin
            history_d = shifted;
            // Non-overlapping mode restarts the fill count so the next match needs len new bits.
            fill_d    = (match && !overlap_q) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            cfg_err_q <= 1'b0;
            history_q <= '0;
            fill_q    <= '0;
            out_q     <= 1'b0;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
            cfg_err_q <= !cfg_len_ok;
            history_q <= '0;
            fill_q    <= '0;
            out_q     <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            out_q     <= match;
        end
    end

    assign out     = out_q;
    assign cfg_err = cfg_err_q;

`ifdef SEQ_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] match_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            match_cnt_q <= '0;
        end else if (match && (match_cnt_q != CntMax)) begin
            match_cnt_q <= match_cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = match_cnt_q;
`endif

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
Parametrised successor to the fixed 3-bit "101" serial detector. Detects a run-time programmable bit pattern of 1..MAX_LEN bits on a qualified serial input. Supports overlapping and non-overlapping match modes. Sits on serial data paths (UART/bit-stream front ends) and drives a registered single-cycle match pulse to downstream control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
DEF_PATTERN, 8'b0000_0101, reset pattern, right-aligned; reset default reproduces "101"
DEF_LEN, 3, reset pattern length (1..MAX_LEN)
DEF_OVERLAP, 1, reset match mode (1 = overlapping)
CNT_W, 8, match counter width (used only with the optional feature)
LEN_W, localparam $clog2(MAX_LEN+1), width of the length field

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  in is sampled only when high
in  input  1  serial data bit
cfg_load  input  1  one-cycle strobe; latches cfg_* fields
cfg_pattern  input  MAX_LEN  pattern, right-aligned; bit [len-1] is received first, bit [0] last
cfg_len  input  LEN_W  pattern length
cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping
out  output  1  registered match pulse
cfg_err  output  1  high while the active configuration is invalid
match_cnt  output  CNT_W  saturating match count (SEQ_MATCH_CNT_EN only)

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Every register updates only on posedge clk.
- Reset values:
  - pattern = DEF_PATTERN, len = DEF_LEN, overlap = DEF_OVERLAP
  - history = 0, fill = 0
  - out = 0, cfg_err = 0, match_cnt = 0
- State:
  - history[MAX_LEN-1:0] shift register; the newest bit enters at [0].
  - fill counter (0..MAX_LEN, saturating) counts valid bits since the last clear.
- Accepted bit (in_valid=1, cfg_load=0, cfg_err=0):
  - history_n = {history[MAX_LEN-2:0], in}
  - fill_n = min(fill+1, MAX_LEN)
  - match = (history_n[len-1:0] == pattern[len-1:0]) && (fill_n >= len)
- Output timing:
  - out is registered: out <= match.
  - out is high for exactly one cycle, in the cycle after the completing bit is sampled. Latency is 1 clock.
- in_valid=0: history and fill hold; out <= 0. Gaps between valid bits are transparent to matching.
- Overlap=1: after a match, fill is unchanged, so the suffix of the match may begin the next match.
- Overlap=0: on a match, fill <= 0 in the same edge. The next match needs len further accepted bits.
- cfg_load=1:
  - Latch pattern, len and overlap.
  - Clear history and fill; out <= 0.
  - Any in bit sampled in the same cycle is discarded (load has priority).
- Invalid length (cfg_len == 0 or cfg_len > MAX_LEN):
  - cfg_err <= 1; the detector is disabled (no bits accepted, out = 0).
  - cfg_err stays high until a load with a valid length. A valid load clears cfg_err on the same edge.
- rst has priority over cfg_load and in_valid. Reset mid-pattern discards partial progress. The first match after reset needs len fresh bits.
- len = 1: every accepted bit equal to pattern[0] gives a pulse; back-to-back pulses are allowed.
- Unused pattern bits above len-1 are ignored.

Optional Feature:
SEQ_MATCH_CNT_EN
- Defined:
  - match_cnt increments on every match (same edge that sets out) and saturates at 2^CNT_W-1.
  - match_cnt is cleared by rst and by cfg_load.
- Undefined:
  - match_cnt port is absent, with no counter logic.
  - All other behaviour is identical.

Test Plan:
1. Reset defaults, overlap, in_valid=1, stream 1,0,1,0,1 -> out pulses in the cycles after bit3 and bit5 (2 pulses); no pulse after bits 1, 2 or 4.
2. Load pattern 101, len=3, overlap=0; stream 1,0,1,0,1,1,0,1 -> pulses after bit3 and bit8 only.
3. Load pattern 8'b1100_1011, len=8; send the pattern with in_valid low on alternate cycles -> single pulse one cycle after the 8th valid bit. Load len=1, pattern[0]=1; stream 1,1,0,1 -> pulses after bits 1, 2 and 4.
4. Load len=0 -> cfg_err=1; stream 101 -> out stays 0. Load len=3 -> cfg_err=0; next 101 gives a pulse. Repeat with len=9 when MAX_LEN=8.
5. Stream 1,0, assert rst one cycle, then stream 1 -> no pulse. cfg_load together with in_valid on the last pattern bit -> bit discarded, no pulse.
6. (SEQ_MATCH_CNT_EN, CNT_W=2) Five len=1 matches -> match_cnt reads 1, 2, 3, 3, 3. cfg_load -> match_cnt = 0.
